rgb_gamma_lut: RTL and testbench
================================

// Module: rgb_gamma_lut
// PURPOSE
//  Per-channel gamma/tone LUT placed directly downstream of color_corrector on the RGB AXI4-Stream video path.
//  Maps each clipped R/G/B pixel through its own 2^PX_WIDTH-entry table and forwards all sideband signals unchanged.
//  Each table is double-buffered: software writes the shadow bank; a committed swap takes effect only at frame start (tuser).
// PARAMETERS
//  PX_WIDTH     10  bits per colour component; also the LUT address and data width
//  TDATA_WIDTH  derived: PX_WIDTH*3 rounded up to a multiple of 8, padding bits at MSB
// PORTS
//  clk_i          in   1         single clock for all logic
//  rst_i          in   1         asynchronous reset, active-high
//  video_i        in   axi4_stream_if.slave   RGB input; TUSER_WIDTH=TID_WIDTH=TDEST_WIDTH=1; tuser=SOF
//  video_o        out  axi4_stream_if.master  mapped RGB output, same layout
//  lut_wr_i       in   1         write strobe into the shadow bank
//  lut_wr_ch_i    in   2         0=R, 1=G, 2=B; 3 = write ignored
//  lut_wr_addr_i  in   PX_WIDTH  table index (input pixel value)
//  lut_wr_data_i  in   PX_WIDTH  output pixel value for that index
//  lut_commit_i   in   1         one-cycle pulse: request a bank swap at the next SOF
//  commit_pend_o  out  1         swap requested but not yet applied
//  bypass_o       out  1         high while output = input (no table committed since reset)
// BEHAVIOUR
//  Lane mapping: R=tdata[3P-1-:P], B=tdata[2P-1-:P], G=tdata[P-1:0]; output pad bits driven 0.
//  Storage: 3 channels x 2 banks x 2^P x P, synchronous read, one write port and one read port per bank; RAM is not reset.
//  State: active_q (bank read by video), pend_q, bypass_q. Reset: active_q=0, pend_q=0, bypass_q=1.
//  Reset values: video_o.tvalid=0, tdata=0, all sidebands 0, commit_pend_o=0, bypass_o=1.
//  Pipeline: 2 stages, S1 = RAM read plus sideband register, S2 = output register. Latency is 2 accepted cycles.
//  Flow control: en = !v2 || video_o.tready; video_i.tready = en.
//   - en also drives the RAM read clock enable, S1 and S2, so the pipeline freezes as a whole.
//   - No beat is dropped or duplicated.
//   - While tvalid=1 and tready=0, tdata and sidebands on video_o hold stable.
//  Swap rule, evaluated on an accepted input beat (tvalid && tready):
//   - pend_nxt = pend_q | lut_commit_i.
//   - If pend_nxt && tuser: active_q toggles, bypass_q clears, pend_q clears.
//   - The SOF beat itself is mapped with the new bank; S1 reads the bank selected by active_nxt.
//   - A commit with no SOF keeps pend_q=1 indefinitely. A repeated commit while pending has no extra effect.
//   - A commit arriving in the same cycle as an accepted SOF beat swaps on that beat.
//  Writes:
//   - Target bank is !active_q as registered at the start of the cycle.
//   - If a swap occurs in the same cycle, the write lands in the bank becoming active (SW must avoid this case).
//   - Writes are accepted every cycle, independent of video flow.
//   - Write-to-read in the same bank and address is not a hazard, since video only reads the active bank.
//  Bypass: while bypass_q=1 (evaluated per beat at S1), S2 takes the delayed input components instead of the RAM data.
//  Mid-frame commit: no visible change until the next SOF beat. Frames are never mixed between banks.
//  Mid-operation reset: pipeline valids clear and state returns to reset values.
//   - RAM contents are kept but are unused until the next commit plus SOF, because bypass_q=1.
//   - Upstream beats in flight are lost; tready resumes at 1 after reset release.
//  commit_pend_o = pend_q; bypass_o = bypass_q (registered outputs).
// TESTING
//  1 After reset, P=10, stream a 4x2 frame with tready=1.
//    -> output equals input, delayed 2 cycles; bypass_o=1; sidebands and tlast positions match.
//  2 Load the inverse LUT (d=1023-a) on all channels, commit mid-frame, then feed R=100,G=0,B=1023.
//    -> current frame is still bypassed; from the next SOF beat output is R=923,G=1023,B=0; bypass_o=0, commit_pend_o falls on that beat.
//  3 Toggle video_o.tready with a random 50% pattern over 3 frames.
//    -> output sequence matches the golden model beat-for-beat; tdata stays stable while stalled.
//  4 Pulse lut_commit_i in the same cycle as an accepted SOF beat.
//    -> that beat already uses the new bank. Commit with no SOF for 1000 cycles -> commit_pend_o stays 1 and no swap occurs.
//  5 Assert rst_i mid-frame with data in both stages.
//    -> tvalid=0 immediately; after release the output is bypassed until a commit plus SOF.
//  6 Run with P=8 (TDATA=24) and P=12 (TDATA=40).
//    -> correct lane mapping; the 4 pad bits of the 40-bit bus read 0; lut_wr_ch_i=3 leaves all tables unchanged.

Source files
------------

// File: rtl/rgb_gamma_lut.sv
// Per-channel gamma/tone LUT for an RGB AXI4-Stream video path.
// Each channel has a double-buffered table. Software writes the shadow bank.
// A committed swap takes effect only on an accepted start-of-frame (tuser) beat.
module rgb_gamma_lut #(
   parameter int unsigned PX_WIDTH = 10,
   localparam int unsigned TDATA_WIDTH = ((PX_WIDTH * 3 + 7) / 8) * 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // RGB input stream
   input  logic [TDATA_WIDTH-1:0] vid_in_tdata_i,
   input  logic                   vid_in_tvalid_i,
   output logic                   vid_in_tready_o,
   input  logic                   vid_in_tlast_i,
   input  logic                   vid_in_tuser_i,
   input  logic                   vid_in_tid_i,
   input  logic                   vid_in_tdest_i,
   // Mapped RGB output stream
   output logic [TDATA_WIDTH-1:0] vid_out_tdata_o,
   output logic                   vid_out_tvalid_o,
   input  logic                   vid_out_tready_i,
   output logic                   vid_out_tlast_o,
   output logic                   vid_out_tuser_o,
   output logic                   vid_out_tid_o,
   output logic                   vid_out_tdest_o,
   // Table load and bank control
   input  logic                   lut_wr_i,
   input  logic [1:0]             lut_wr_ch_i,
   input  logic [PX_WIDTH-1:0]    lut_wr_addr_i,
   input  logic [PX_WIDTH-1:0]    lut_wr_data_i,
   input  logic                   lut_commit_i,
   output logic                   commit_pend_o,
   output logic                   bypass_o
);

   localparam int unsigned P     = PX_WIDTH;
   localparam int unsigned Depth = 1 << PX_WIDTH;

   // Bank control state
   logic active_q, active_d;
   logic pend_q, pend_d;
   logic bypass_q, bypass_d;
   logic pend_nxt, swap, en, acc;

   // Input components
   logic [P-1:0] in_r, in_g, in_b;

   // Stage 1: RAM read data plus delayed input and sidebands
   logic         v1_q, v1_d;
   logic [3*P-1:0] px1_q, px1_d;
   logic [3:0]   sb1_q, sb1_d;
   logic         byp1_q, byp1_d;
   logic [P-1:0] rd_r_q, rd_g_q, rd_b_q;

   // Stage 2: output register
   logic         v2_q, v2_d;
   logic [TDATA_WIDTH-1:0] data2_q, data2_d;
   logic [3:0]   sb2_q, sb2_d;

   // Tables: [bank][index]
   logic [P-1:0] lut_r_mem [2][Depth];
   logic [P-1:0] lut_g_mem [2][Depth];
   logic [P-1:0] lut_b_mem [2][Depth];

   // Input pad bits carry no information
   logic unused_pad;
   assign unused_pad = ^vid_in_tdata_i;

   assign in_r = vid_in_tdata_i[3*P-1 -: P];
   assign in_b = vid_in_tdata_i[2*P-1 -: P];
   assign in_g = vid_in_tdata_i[P-1:0];

   // Flow control and bank-swap decision
   always_comb begin
      en       = !v2_q || vid_out_tready_i;
      acc      = vid_in_tvalid_i && en;
      pend_nxt = pend_q | lut_commit_i;
      swap     = acc && pend_nxt && vid_in_tuser_i;
      active_d = active_q ^ swap;
      pend_d   = pend_nxt && !swap;
      bypass_d = bypass_q && !swap;
   end

   // Pipeline next-state; the whole pipeline freezes when en is low
   always_comb begin
      v1_d    = v1_q;
      px1_d   = px1_q;
      sb1_d   = sb1_q;
      byp1_d  = byp1_q;
      v2_d    = v2_q;
      data2_d = data2_q;
      sb2_d   = sb2_q;
      if (en) begin
         v1_d    = vid_in_tvalid_i;
         px1_d   = {in_r, in_b, in_g};
         sb1_d   = {vid_in_tlast_i, vid_in_tuser_i, vid_in_tid_i, vid_in_tdest_i};
         // Bypass is decided with the post-swap state so the SOF beat sees the new bank
         byp1_d  = bypass_d;
         v2_d    = v1_q;
         data2_d = '0;
         data2_d[3*P-1:0] = byp1_q ? px1_q : {rd_r_q, rd_b_q, rd_g_q};
         sb2_d   = sb1_q;
      end
   end

   // Control and pipeline registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         pend_q   <= 1'b0;
         bypass_q <= 1'b1;
         v1_q     <= 1'b0;
         px1_q    <= '0;
         sb1_q    <= '0;
         byp1_q   <= 1'b1;
         v2_q     <= 1'b0;
         data2_q  <= '0;
         sb2_q    <= '0;
      end else begin
         active_q <= active_d;
         pend_q   <= pend_d;
         bypass_q <= bypass_d;
         v1_q     <= v1_d;
         px1_q    <= px1_d;
         sb1_q    <= sb1_d;
         byp1_q   <= byp1_d;
         v2_q     <= v2_d;
         data2_q  <= data2_d;
         sb2_q    <= sb2_d;
      end
   end

   // Table RAMs: shadow-bank write, active-bank synchronous read (not reset)
   always_ff @(posedge clk_i) begin
      if (lut_wr_i) begin
         case (lut_wr_ch_i)
            2'd0:    lut_r_mem[!active_q][lut_wr_addr_i] <= lut_wr_data_i;
            2'd1:    lut_g_mem[!active_q][lut_wr_addr_i] <= lut_wr_data_i;
            2'd2:    lut_b_mem[!active_q][lut_wr_addr_i] <= lut_wr_data_i;
            default: ;
         endcase
      end
      if (en) begin
         rd_r_q <= lut_r_mem[active_d][in_r];
         rd_g_q <= lut_g_mem[active_d][in_g];
         rd_b_q <= lut_b_mem[active_d][in_b];
      end
   end

   assign vid_in_tready_o  = en;
   assign vid_out_tvalid_o = v2_q;
   assign vid_out_tdata_o  = data2_q;
   assign vid_out_tlast_o  = sb2_q[3];
   assign vid_out_tuser_o  = sb2_q[2];
   assign vid_out_tid_o    = sb2_q[1];
   assign vid_out_tdest_o  = sb2_q[0];
   assign commit_pend_o    = pend_q;
   assign bypass_o         = bypass_q;

endmodule

// File: tb/tb_rgb_gamma_lut.sv
// Self-checking bench for rgb_gamma_lut: scoreboard-checked 10-bit instance plus
// directed lane/pad/channel-3 checks on a 12-bit instance.
module tb_rgb_gamma_lut;

   localparam int unsigned P  = 10;
   localparam int unsigned TW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [TW-1:0] in_tdata;
   logic in_tvalid, in_tready, in_tlast, in_tuser, in_tid, in_tdest;
   logic [TW-1:0] out_tdata;
   logic out_tvalid, out_tlast, out_tuser, out_tid, out_tdest;
   logic out_tready = 1'b1;
   logic lut_wr, lut_commit, commit_pend, bypass;
   logic [1:0] lut_wr_ch;
   logic [P-1:0] lut_wr_addr, lut_wr_data;

   // 12-bit instance
   logic [39:0] b_in_tdata, b_out_tdata;
   logic b_in_tvalid, b_in_tready, b_in_tuser;
   logic b_out_tvalid, b_out_tlast, b_out_tuser, b_out_tid, b_out_tdest;
   logic b_lut_wr, b_lut_commit, b_commit_pend, b_bypass;
   logic [1:0] b_lut_wr_ch;
   logic [11:0] b_lut_wr_addr, b_lut_wr_data;

   rgb_gamma_lut #(.PX_WIDTH(P)) dut (
      .clk_i(clk), .rst_i(rst),
      .vid_in_tdata_i(in_tdata), .vid_in_tvalid_i(in_tvalid), .vid_in_tready_o(in_tready),
      .vid_in_tlast_i(in_tlast), .vid_in_tuser_i(in_tuser), .vid_in_tid_i(in_tid),
      .vid_in_tdest_i(in_tdest),
      .vid_out_tdata_o(out_tdata), .vid_out_tvalid_o(out_tvalid),
      .vid_out_tready_i(out_tready), .vid_out_tlast_o(out_tlast),
      .vid_out_tuser_o(out_tuser), .vid_out_tid_o(out_tid), .vid_out_tdest_o(out_tdest),
      .lut_wr_i(lut_wr), .lut_wr_ch_i(lut_wr_ch), .lut_wr_addr_i(lut_wr_addr),
      .lut_wr_data_i(lut_wr_data), .lut_commit_i(lut_commit),
      .commit_pend_o(commit_pend), .bypass_o(bypass)
   );

   rgb_gamma_lut #(.PX_WIDTH(12)) dut12 (
      .clk_i(clk), .rst_i(rst),
      .vid_in_tdata_i(b_in_tdata), .vid_in_tvalid_i(b_in_tvalid),
      .vid_in_tready_o(b_in_tready), .vid_in_tlast_i(1'b0), .vid_in_tuser_i(b_in_tuser),
      .vid_in_tid_i(1'b0), .vid_in_tdest_i(1'b0),
      .vid_out_tdata_o(b_out_tdata), .vid_out_tvalid_o(b_out_tvalid),
      .vid_out_tready_i(1'b1), .vid_out_tlast_o(b_out_tlast),
      .vid_out_tuser_o(b_out_tuser), .vid_out_tid_o(b_out_tid), .vid_out_tdest_o(b_out_tdest),
      .lut_wr_i(b_lut_wr), .lut_wr_ch_i(b_lut_wr_ch), .lut_wr_addr_i(b_lut_wr_addr),
      .lut_wr_data_i(b_lut_wr_data), .lut_commit_i(b_lut_commit),
      .commit_pend_o(b_commit_pend), .bypass_o(b_bypass)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
   bit lat_chk = 1'b0;

   typedef struct packed {
      logic [TW-1:0] d;
      logic [3:0]    sb;
      int            stamp;
   } beat_t;

   beat_t sb_q[$];
   beat_t exp_b, last_obs;
   logic [P-1:0] m_lut [3][2][1 << P];
   bit m_active, m_pend, m_bypass, old_act, pend_nxt;
   bit held_v;
   logic [TW+3:0] held;
   logic [P-1:0] mr, mg, mb;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [P-1:0] lut_val(input int kind, input int ch, input int a);
      if (kind == 0) return P'(1023 - a);
      return P'(a ^ (341 + ch * 37));
   endfunction

   always @(posedge clk) cyc++;

   // Output ready pattern
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_tready = 1'b1;
         1:       out_tready = 1'($urandom_range(0, 1));
         default: out_tready = 1'b0;
      endcase
   end

   // Reference model and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         m_pend   = 1'b0;
         m_bypass = 1'b1;
         held_v   = 1'b0;
         sb_q.delete();
      end else begin
         chk("commit_pend", 64'(commit_pend), 64'(m_pend));
         chk("bypass", 64'(bypass), 64'(m_bypass));
         if (held_v)
            chk("stall_hold", {out_tvalid, out_tdata, out_tlast, out_tuser, out_tid, out_tdest},
                {1'b1, held});
         held_v = out_tvalid && !out_tready;
         held   = {out_tdata, out_tlast, out_tuser, out_tid, out_tdest};
         if (out_tvalid && out_tready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_beat", 64'(sb_q.size()), 64'd1);
            end else begin
               exp_b = sb_q.pop_front();
               chk("beat", {out_tdata, out_tlast, out_tuser, out_tid, out_tdest},
                   {exp_b.d, exp_b.sb});
               if (lat_chk) chk("latency", 64'(cyc - exp_b.stamp), 64'd2);
               last_obs.d  = out_tdata;
               last_obs.sb = {out_tlast, out_tuser, out_tid, out_tdest};
            end
         end
         old_act = m_active;
         if (in_tvalid && in_tready) begin
            pend_nxt = m_pend | lut_commit;
            if (pend_nxt && in_tuser) begin
               m_active = ~m_active;
               m_bypass = 1'b0;
               m_pend   = 1'b0;
            end else begin
               m_pend = pend_nxt;
            end
            mr = in_tdata[3*P-1 -: P];
            mb = in_tdata[2*P-1 -: P];
            mg = in_tdata[P-1:0];
            exp_b.d = '0;
            if (m_bypass) exp_b.d[3*P-1:0] = {mr, mb, mg};
            else exp_b.d[3*P-1:0] = {m_lut[0][m_active][mr], m_lut[2][m_active][mb],
                                     m_lut[1][m_active][mg]};
            exp_b.sb    = {in_tlast, in_tuser, in_tid, in_tdest};
            exp_b.stamp = cyc;
            sb_q.push_back(exp_b);
         end else begin
            m_pend = m_pend | lut_commit;
         end
         if (lut_wr && lut_wr_ch != 2'd3) m_lut[lut_wr_ch][!old_act][lut_wr_addr] = lut_wr_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [P-1:0] r, g, b, input bit sof, last, commit);
      bit ok = 1'b0;
      in_tdata   = {2'b00, r, b, g};
      in_tvalid  = 1'b1;
      in_tuser   = sof;
      in_tlast   = last;
      in_tid     = 1'($urandom_range(0, 1));
      in_tdest   = 1'($urandom_range(0, 1));
      lut_commit = commit;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'(in_tready), 64'd1);
      tick();
      in_tvalid  = 1'b0;
      lut_commit = 1'b0;
   endtask

   // 4x2 frame; kind 0 = random pixels, kind 1 = fixed (100, 0, 1023)
   task automatic send_frame(input int kind, input int commit_at, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (kind == 0)
            send_beat(P'($urandom), P'($urandom), P'($urandom), i == 0, (i % 4) == 3,
                      i == commit_at);
         else
            send_beat(10'd100, 10'd0, 10'd1023, i == 0, (i % 4) == 3, i == commit_at);
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (sb_q.size() == 0) break;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
      tick();
   endtask

   task automatic load_lut(input int kind);
      for (int ch = 0; ch < 3; ch++) begin
         for (int a = 0; a < (1 << P); a++) begin
            lut_wr      = 1'b1;
            lut_wr_ch   = 2'(ch);
            lut_wr_addr = P'(a);
            lut_wr_data = lut_val(kind, ch, a);
            tick();
         end
      end
      lut_wr = 1'b0;
   endtask

   task automatic b_write(input logic [1:0] ch, input logic [11:0] a, d);
      b_lut_wr      = 1'b1;
      b_lut_wr_ch   = ch;
      b_lut_wr_addr = a;
      b_lut_wr_data = d;
      tick();
      b_lut_wr = 1'b0;
   endtask

   // Single 12-bit beat; returns output bus (b_in_tready is always 1 there)
   task automatic b_beat(input logic [39:0] d, input bit sof, commit, output logic [39:0] o);
      bit ok = 1'b0;
      b_in_tdata   = d;
      b_in_tvalid  = 1'b1;
      b_in_tuser   = sof;
      b_lut_commit = commit;
      tick();
      b_in_tvalid  = 1'b0;
      b_lut_commit = 1'b0;
      o = '0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (b_out_tvalid) begin
            ok = 1'b1;
            o  = b_out_tdata;
            break;
         end
      end
      if (!ok) chk("p12_timeout", 64'(b_out_tvalid), 64'd1);
      tick();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] o12;
      rst = 1'b1;
      in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tuser = 1'b0;
      in_tid = 1'b0; in_tdest = 1'b0;
      lut_wr = 1'b0; lut_wr_ch = 2'd0; lut_wr_addr = '0; lut_wr_data = '0; lut_commit = 1'b0;
      b_in_tdata = '0; b_in_tvalid = 1'b0; b_in_tuser = 1'b0; b_lut_wr = 1'b0;
      b_lut_wr_ch = 2'd0; b_lut_wr_addr = '0; b_lut_wr_data = '0; b_lut_commit = 1'b0;
      repeat (3) tick();
      chk("rst_tvalid", 64'(out_tvalid), 64'd0);
      chk("rst_tdata", 64'(out_tdata), 64'd0);
      chk("rst_sideband", {out_tlast, out_tuser, out_tid, out_tdest}, 64'd0);
      chk("rst_pend", 64'(commit_pend), 64'd0);
      chk("rst_bypass", 64'(bypass), 64'd1);
      rst = 1'b0;
      tick();

      // 1: bypass after reset, gapless, fixed latency
      lat_chk = 1'b1;
      send_frame(0, -1, 1'b0);
      drain();
      lat_chk = 1'b0;
      chk("t1_bypass", 64'(bypass), 64'd1);

      // 2: inverse table, commit mid-frame
      load_lut(0);
      send_frame(1, 2, 1'b0);
      drain();
      chk("t2_still_bypassed", 64'(last_obs.d), {34'd0, 10'd100, 10'd1023, 10'd0});
      chk("t2_pending", 64'(commit_pend), 64'd1);
      send_frame(1, -1, 1'b0);
      drain();
      chk("t2_inverse", 64'(last_obs.d), {34'd0, 10'd923, 10'd0, 10'd1023});
      chk("t2_bypass_off", 64'(bypass), 64'd0);
      chk("t2_pend_clear", 64'(commit_pend), 64'd0);

      // 3: random backpressure and input gaps over 3 frames
      rdy_mode = 1;
      repeat (3) send_frame(0, -1, 1'b1);
      rdy_mode = 0;
      drain();

      // 4: commit on the SOF beat itself, then a commit with no SOF
      load_lut(1);
      send_beat(10'd5, 10'd6, 10'd7, 1'b1, 1'b0, 1'b1);
      drain();
      chk("t4_sof_commit", 64'(last_obs.d),
          {34'd0, lut_val(1, 0, 5), lut_val(1, 2, 7), lut_val(1, 1, 6)});
      lut_commit = 1'b1;
      tick();
      lut_commit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         repeat (100) tick();
         send_beat(P'($urandom), P'($urandom), P'($urandom), 1'b0, 1'b0, 1'b0);
      end
      drain();
      chk("t4_pend_held", 64'(commit_pend), 64'd1);
      send_beat(10'd5, 10'd6, 10'd7, 1'b0, 1'b1, 1'b0);
      drain();
      chk("t4_no_swap", 64'(last_obs.d),
          {34'd0, lut_val(1, 0, 5), lut_val(1, 2, 7), lut_val(1, 1, 6)});

      // 5: reset with both stages full
      rdy_mode = 2;
      repeat (3) tick();
      send_beat(10'd1, 10'd2, 10'd3, 1'b1, 1'b0, 1'b0);
      send_beat(10'd4, 10'd5, 10'd6, 1'b0, 1'b0, 1'b0);
      chk("t5_full_valid", 64'(out_tvalid), 64'd1);
      chk("t5_full_stall", 64'(in_tready), 64'd0);
      rst = 1'b1;
      #1;
      chk("t5_rst_tvalid", 64'(out_tvalid), 64'd0);
      chk("t5_rst_pend", 64'(commit_pend), 64'd0);
      chk("t5_rst_bypass", 64'(bypass), 64'd1);
      rdy_mode = 0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("t5_tready", 64'(in_tready), 64'd1);
      send_beat(10'd100, 10'd0, 10'd1023, 1'b1, 1'b0, 1'b0);
      drain();
      chk("t5_bypassed", 64'(last_obs.d), {34'd0, 10'd100, 10'd1023, 10'd0});
      send_beat(10'd100, 10'd0, 10'd1023, 1'b1, 1'b0, 1'b1);
      drain();
      chk("t5_ram_kept", 64'(last_obs.d), {34'd0, 10'd923, 10'd0, 10'd1023});

      // 6: 12-bit lanes, pad bits, ignored channel 3
      b_beat({4'h0, 12'habc, 12'hfed, 12'h123}, 1'b1, 1'b0, o12);
      chk("p12_bypass", 64'(o12), {24'd0, 4'h0, 12'habc, 12'hfed, 12'h123});
      b_write(2'd0, 12'habc, 12'h111);
      b_write(2'd1, 12'h123, 12'h222);
      b_write(2'd2, 12'hfed, 12'h333);
      b_write(2'd3, 12'habc, 12'hfff);
      b_write(2'd3, 12'h123, 12'hfff);
      b_write(2'd3, 12'hfed, 12'hfff);
      b_beat({4'hf, 12'habc, 12'hfed, 12'h123}, 1'b1, 1'b1, o12);
      chk("p12_mapped", 64'(o12), {24'd0, 4'h0, 12'h111, 12'h333, 12'h222});
      chk("p12_bypass_off", 64'(b_bypass), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
